// File: rtl/regfile_clr_dbg.sv
// Parametrised 2R/1W register file with a sequential range-clear engine,
// optional write-to-read forwarding and a freezable 7-segment debug view.
module regfile_clr_dbg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CLR_LO = 2,
  parameter int CLR_HI = 25,
  parameter int FWD    = 1,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [ADDR_W-1:0]     wa3,
  input  logic [DATA_W-1:0]     wd3,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     dbg_sel,
  input  logic                  dbg_freeze,
  output logic [7*DIGITS-1:0]   seg
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rf [2**ADDR_W];

  localparam logic [ADDR_W-1:0] PTR_LO = ADDR_W'(CLR_LO);
  localparam logic [ADDR_W-1:0] PTR_HI = ADDR_W'(CLR_HI);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = PTR_LO;
        end
      end
      CLEAR: begin
        if (ptr_q == PTR_HI) state_d = IDLE;
        else                 ptr_d   = ptr_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset restarts the clear from the bottom of the range
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= PTR_LO;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // Array update: the user write is issued last so it wins a collision with the clear
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) rf[ptr_q] <= '0;
    if (we3 && (wa3 != '0)) rf[wa3] <= wd3;
  end

  assign rd1 = (ra1 == '0) ? '0 :
               ((FWD != 0) && we3 && (wa3 == ra1)) ? wd3 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 :
               ((FWD != 0) && we3 && (wa3 == ra2)) ? wd3 : rf[ra2];

  // Display stage: samples the array as it was before this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= '1;
    end else if (!dbg_freeze) begin
      for (int i = 0; i < DIGITS; i++) begin
        seg[7*i +: 7] <= hex7((dbg_sel == '0) ? 4'h0 : rf[dbg_sel][4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_clr_dbg.sv
// Directed bench for regfile_clr_dbg: default, FWD=0 and DIGITS=8 instances
// share one stimulus stream; expectations are hand-computed constants.
module tb_regfile_clr_dbg;

  logic        clk = 1'b0;
  logic        reset, we3, clr_req, dbg_freeze;
  logic [4:0]  wa3, ra1, ra2, dbg_sel;
  logic [31:0] wd3;

  logic [31:0] rd1, rd2, rd1_nf, rd2_nf, rd1_8, rd2_8;
  logic        busy, busy_nf, busy_8;
  logic [27:0] seg, seg_nf;
  logic [55:0] seg_8;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  localparam logic [6:0] H0 = 7'b1000000, H3 = 7'b0110000, H8 = 7'b0000000;
  localparam logic [6:0] H9 = 7'b0010000, HA = 7'b0001000, HB = 7'b0000011;
  localparam logic [6:0] HC = 7'b1000110, HD = 7'b0100001, HE = 7'b0000110;
  localparam logic [6:0] HF = 7'b0001110;

  regfile_clr_dbg dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .clr_req(clr_req),
    .busy(busy), .dbg_sel(dbg_sel), .dbg_freeze(dbg_freeze), .seg(seg)
  );

  regfile_clr_dbg #(.FWD(0)) dut_nf (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nf), .rd2(rd2_nf), .clr_req(clr_req),
    .busy(busy_nf), .dbg_sel(dbg_sel), .dbg_freeze(dbg_freeze), .seg(seg_nf)
  );

  regfile_clr_dbg #(.DIGITS(8)) dut8 (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_8), .rd2(rd2_8), .clr_req(clr_req),
    .busy(busy_8), .dbg_sel(dbg_sel), .dbg_freeze(dbg_freeze), .seg(seg_8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] enf;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we3 = 1'b1; wa3 = a; wd3 = d;
    tick();
    we3 = 1'b0;
  endtask

  // Counts cycles with busy high, starting from the current sample point
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'h1111_1111, 5'd26, 5'd2,  32'h1234_5678, 32'h0,         32'h1234_5678};
    vt[1] = '{1'b1, 5'd5,  32'hA5A5_0001, 5'd5,  5'd5,  32'hA5A5_0001, 32'hA5A5_0001, 32'h1111_1111};
    vt[2] = '{1'b0, 5'd5,  32'h0,         5'd5,  5'd0,  32'hA5A5_0001, 32'h0,         32'hA5A5_0001};
    vt[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
    vt[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd25, 32'h0,         32'h0,         32'h0};
    vt[5] = '{1'b1, 5'd26, 32'hCAFE_F00D, 5'd26, 5'd5,  32'hCAFE_F00D, 32'hA5A5_0001, 32'h1234_5678};
    vt[6] = '{1'b1, 5'd1,  32'h0000_0042, 5'd26, 5'd1,  32'hCAFE_F00D, 32'h0000_0042, 32'hCAFE_F00D};
    vt[7] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd26, 32'h0000_0042, 32'hCAFE_F00D, 32'h0000_0042};

    reset = 1'b1; we3 = 1'b0; clr_req = 1'b0; dbg_freeze = 1'b0;
    wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0; dbg_sel = '0;

    tick();
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_seg", 64'(seg), 64'hFFF_FFFF);
    check("reset_seg8", 64'(seg_8), 64'hFF_FFFF_FFFF_FFFF);
    reset = 1'b0;
    count_busy(cnt);
    check("init_clear_len", 64'(cnt), 64'd24);

    wr(5'd2, 32'hDEAD_BEEF);
    wr(5'd25, 32'hDEAD_BEEF);
    wr(5'd26, 32'h1234_5678);
    ra1 = 5'd2; ra2 = 5'd25; #1;
    check("pre_rst_r2", 64'(rd1), 64'hDEAD_BEEF);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(cnt);
    check("rst_clear_len", 64'(cnt), 64'd24);
    ra1 = 5'd2; ra2 = 5'd25; #1;
    check("r2_cleared", 64'(rd1), 64'h0);
    check("r25_cleared", 64'(rd2), 64'h0);
    ra1 = 5'd26; #1;
    check("r26_kept", 64'(rd1), 64'h1234_5678);

    for (int i = 0; i < 8; i++) begin
      we3 = vt[i].we; wa3 = vt[i].wa; wd3 = vt[i].wd;
      ra1 = vt[i].r1; ra2 = vt[i].r2;
      #1;
      check($sformatf("vec%0d_rd1", i), 64'(rd1), 64'(vt[i].e1));
      check($sformatf("vec%0d_rd2", i), 64'(rd2), 64'(vt[i].e2));
      check($sformatf("vec%0d_rd1_nf", i), 64'(rd1_nf), 64'(vt[i].enf));
      tick();
    end
    we3 = 1'b0;

    // Clear request with a colliding write at ptr==10 and an ignored re-request
    wr(5'd3, 32'h0000_0099);
    wr(5'd10, 32'h0000_1234);
    check("idle_busy", 64'(busy), 64'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy_rise", 64'(busy), 64'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      we3 = (cnt == 8); wa3 = 5'd10; wd3 = 32'h77;
      clr_req = (cnt == 13);
      cnt++;
      tick();
    end
    we3 = 1'b0; clr_req = 1'b0;
    check("clr_len_with_rereq", 64'(cnt), 64'd24);
    ra1 = 5'd10; ra2 = 5'd3; #1;
    check("r10_collision", 64'(rd1), 64'h77);
    check("r3_cleared", 64'(rd2), 64'h0);
    ra1 = 5'd1; ra2 = 5'd26; #1;
    check("r1_kept", 64'(rd1), 64'h42);
    check("r26_kept2", 64'(rd2), 64'hCAFE_F00D);
    tick();
    check("clr_no_requeue", 64'(busy), 64'd0);

    // Reset asserted mid-clear at ptr==15
    dbg_sel = 5'd26;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (13) tick();
    check("midclr_busy", 64'(busy), 64'd1);
    check("seg_before_rst", 64'(seg), 64'({HF, H0, H0, HD}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midclr_rst_seg", 64'(seg), 64'hFFF_FFFF);
    count_busy(cnt);
    check("midclr_rst_len", 64'(cnt), 64'd24);

    // Display pipeline and freeze
    dbg_sel = 5'd7;
    wr(5'd7, 32'h0000_3C9A);
    tick();
    check("seg_r7", 64'(seg), 64'({H3, HC, H9, HA}));
    check("seg8_r7", 64'(seg_8), 64'({H0, H0, H0, H0, H3, HC, H9, HA}));
    dbg_freeze = 1'b1;
    wr(5'd7, 32'h0);
    tick();
    check("seg_frozen", 64'(seg), 64'({H3, HC, H9, HA}));
    dbg_freeze = 1'b0;
    tick();
    check("seg_unfrozen", 64'(seg), 64'({H0, H0, H0, H0}));

    dbg_sel = 5'd3;
    wr(5'd3, 32'hFEDC_BA98);
    tick();
    check("seg8_r3", 64'(seg_8), 64'({HF, HE, HD, HC, HB, HA, H9, H8}));
    check("seg_r3_low", 64'(seg), 64'({HB, HA, H9, H8}));
    dbg_sel = 5'd0;
    tick();
    check("seg_sel0", 64'(seg), 64'({H0, H0, H0, H0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
